fifo_uart_tx: RTL and testbench

- Drains the synchronous byte FIFO on its read side and serializes each word onto a single asynchronous serial line.
- Frame format: start bit, data bits LSB first, optional even parity bit, stop bit.
- Sits directly downstream of the FIFO: it connects to the FIFO's empty, data_out and read_en ports and pops exactly one word per frame.
- Single clock domain. No flow control beyond FIFO empty and the local enable.

---
 rtl/fifo_uart_tx.sv | 91 +++++++++
 tb/tb_fifo_uart_tx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one FIFO word per frame and serializes it as start, LSB-first data, optional even parity, stop
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int BIT_CNT_SIZE = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  localparam logic [BIT_CNT_SIZE-1:0] LAST_CNT = BIT_CNT_SIZE'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  logic [2:0]              state_q, state_d;
  logic [BIT_CNT_SIZE-1:0] cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d, tx_q, tx_d, done_q, done_d, bit_end;
  logic [15:0]             count_q, count_d;
  // next-state logic; tx is precomputed from the next state so the line changes on the bit boundary edge
  always_comb begin
    bit_end    = cnt_q == LAST_CNT;
    fifo_rd_en = reset & enable & ~fifo_empty & (state_q == IDLE);
    state_d    = state_q;
    cnt_d      = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    done_d     = 1'b0;
    count_d    = count_q;
    case (state_q)
      IDLE: if (fifo_rd_en) begin
        state_d = START;
        shift_d = fifo_data;
        par_d   = ^fifo_data;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
        count_d = count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  // state registers; reset abandons any frame in flight and returns the line high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end
  assign tx          = tx_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = done_q;
  assign frame_count = count_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of framing, pacing, parity, gating, reset and count wrap
module tb_fifo_uart_tx;
  logic clk = 1'b0, reset = 1'b1, enable0 = 1'b0, enable1 = 1'b0;
  logic fifo_empty0, fifo_empty1, rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;
  logic [7:0] fifo_data0, fifo_data1;
  logic [15:0] count0, count1;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0, cyc = 0, checks = 0, errors = 0;
  int pc, prev;
  logic lo;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd0) rp0 <= rp0 + 1;
  always @(posedge clk) if (rd1) rp1 <= rp1 + 1;
  assign fifo_empty0 = wp0 == rp0;
  assign fifo_empty1 = wp1 == rp1;
  assign fifo_data0  = mem0[rp0[3:0]];
  assign fifo_data1  = mem1[rp1[3:0]];
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .BIT_CNT_SIZE(16), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .fifo_empty(fifo_empty0), .fifo_data(fifo_data0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(done0), .frame_count(count0));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .BIT_CNT_SIZE(16), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(done1), .frame_count(count1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push0(input logic [7:0] d);
    mem0[wp0[3:0]] = d;
    wp0++;
  endtask
  task automatic push1(input logic [7:0] d);
    mem1[wp1[3:0]] = d;
    wp1++;
  endtask
  // waits for a pop, then checks every cycle of the frame and the frame_done cycle
  task automatic do_frame(input bit p, input logic [7:0] d, output int pop_cyc);
    int n, nb;
    logic [10:0] bits;
    nb   = p ? 11 : 10;
    bits = p ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
    n    = 0;
    #1;
    while (!(p ? rd1 : rd0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pop", p ? rd1 : rd0, 1);
    pop_cyc = cyc;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("tx_b%0d_c%0d", b, k), p ? tx1 : tx0, bits[b]);
        chk("busy_frame", p ? busy1 : busy0, 1);
        chk("rd_frame", p ? rd1 : rd0, 0);
        chk("done_frame", p ? done1 : done0, 0);
      end
    @(negedge clk);
    chk("done_pulse", p ? done1 : done0, 1);
    chk("busy_done", p ? busy1 : busy0, 0);
    chk("tx_gap", p ? tx1 : tx0, 1);
  endtask
  initial begin
    #2 reset = 1'b0;
    enable0 = 1'b1;
    push0(8'hA5);
    #3;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_count", count0, 0);
    chk("rst_rd", rd0, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_pops", rp0, 0);
    reset = 1'b1;
    do_frame(0, 8'hA5, pc);
    chk("basic_count", count0, 1);
    chk("basic_pops", rp0, 1);
    @(negedge clk);
    chk("basic_done_off", done0, 0);
    chk("basic_idle_busy", busy0, 0);
    push0(8'h00);
    push0(8'hFF);
    push0(8'h3C);
    do_frame(0, 8'h00, pc);
    prev = pc;
    do_frame(0, 8'hFF, pc);
    chk("b2b_gap1", pc - prev, 41);
    prev = pc;
    do_frame(0, 8'h3C, pc);
    chk("b2b_gap2", pc - prev, 41);
    chk("b2b_count", count0, 4);
    repeat (50) @(negedge clk);
    chk("b2b_no_extra_pop", rp0, 4);
    chk("b2b_idle_tx", tx0, 1);
    enable0 = 1'b0;
    push0(8'h55);
    push0(8'h66);
    lo = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!tx0 || rd0) lo = 1'b1;
    end
    chk("gate_quiet", lo, 0);
    chk("gate_pops", rp0, 4);
    enable0 = 1'b1;
    fork
      do_frame(0, 8'h55, pc);
      begin
        repeat (10) @(negedge clk);
        enable0 = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    chk("gate_one_pop", rp0, 5);
    chk("gate_count", count0, 5);
    chk("gate_tx_idle", tx0, 1);
    enable0 = 1'b1;
    #1;
    chk("rmid_pop", rd0, 1);
    repeat (18) @(negedge clk);
    chk("rmid_bit3", tx0, 0);
    chk("rmid_busy", busy0, 1);
    #1 reset = 1'b0;
    #1;
    chk("rmid_tx_async", tx0, 1);
    chk("rmid_busy_async", busy0, 0);
    chk("rmid_rd", rd0, 0);
    push0(8'h81);
    repeat (3) @(negedge clk);
    chk("rmid_no_done", done0, 0);
    chk("rmid_count", count0, 0);
    reset = 1'b1;
    do_frame(0, 8'h81, pc);
    chk("rmid_after_count", count0, 1);
    force dut0.count_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut0.count_q;
    @(negedge clk);
    chk("wrap_preload", count0, 16'hFFFF);
    push0(8'h5A);
    do_frame(0, 8'h5A, pc);
    chk("wrap_count", count0, 0);
    enable1 = 1'b1;
    push1(8'h07);
    push1(8'h03);
    do_frame(1, 8'h07, pc);
    prev = pc;
    do_frame(1, 8'h03, pc);
    chk("par_gap", pc - prev, 45);
    chk("par_count", count1, 2);
    chk("par_pops", rp1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
